// File: rtl/abm_req_arbiter.sv
// Purpose: round-robin arbiter merging two ABM DMA read request streams onto one downstream request register.
// Latency: 1 cycle from requester handshake to m_valid; at most one request every 2 cycles.
// Backpressure: while the output register is full (ISSUE), neither requester sees ready; m_* holds until m_ready.
// Optional feature: define ABM_ARB_COUNTERS_EN for per-channel handshake counters (otherwise the counters read 0).
module abm_req_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pci_src_addr,
    input  logic        start0,
    input  logic        start1,
    input  logic        start_wstrobe,
    input  logic        req0_valid,
    input  logic [31:0] req0_offset,
    input  logic [15:0] req0_len,
    input  logic        req0_last,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_offset,
    input  logic [15:0] req1_len,
    input  logic        req1_last,
    output logic        req1_ready,
    output logic        m_valid,
    output logic [63:0] m_addr,
    output logic [15:0] m_len,
    output logic        m_src,
    input  logic        m_ready,
    output logic        idle0,
    output logic        idle1,
    output logic [31:0] abm0_counter,
    output logic [31:0] abm1_counter
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic        active0_q, active0_d;
    logic        active1_q, active1_d;
    // Channel granted most recently; resets to 1 so channel 0 wins the first tie.
    logic        rr_last_q, rr_last_d;
    logic [63:0] addr_q, addr_d;
    logic [15:0] len_q, len_d;
    logic        src_q, src_d;

    logic        elig0, elig1;
    logic        grant0, grant1;
    logic        m_hs;

    // Eligibility and round-robin grant among requesters that are both valid and active
    always_comb begin
        elig0  = req0_valid & active0_q;
        elig1  = req1_valid & active1_q;
        grant0 = elig0 & (~elig1 | rr_last_q);
        grant1 = elig1 & (~elig0 | ~rr_last_q);
    end

    // A ready is only offered while the output register is empty, so ready doubles as the handshake
    assign req0_ready = (state_q == ST_IDLE) & grant0;
    assign req1_ready = (state_q == ST_IDLE) & grant1;
    assign m_hs       = (state_q == ST_ISSUE) & m_ready;

    // Next-state: capture a granted request in IDLE, release it on the downstream handshake
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        len_d     = len_q;
        src_d     = src_q;
        rr_last_d = rr_last_q;
        case (state_q)
            ST_IDLE: begin
                if (req0_ready | req1_ready) begin
                    state_d   = ST_ISSUE;
                    src_d     = req1_ready;
                    rr_last_d = req1_ready;
                    // Base snapshot is taken here; later base changes do not touch the held address
                    addr_d    = pci_src_addr + {32'd0, (req1_ready ? req1_offset : req0_offset)};
                    len_d     = req1_ready ? req1_len : req0_len;
                end
            end
            ST_ISSUE: begin
                if (m_hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Channel run flags: a last-request capture stops the channel, a software write overrides it
    always_comb begin
        active0_d = active0_q;
        active1_d = active1_q;
        if (req0_ready & req0_last) begin
            active0_d = 1'b0;
        end
        if (req1_ready & req1_last) begin
            active1_d = 1'b0;
        end
        if (start_wstrobe) begin
            active0_d = start0;
            active1_d = start1;
        end
    end

    // State and output register; reset drops any held request
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            active0_q <= 1'b0;
            active1_q <= 1'b0;
            rr_last_q <= 1'b1;
            addr_q    <= 64'd0;
            len_q     <= 16'd0;
            src_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            active0_q <= active0_d;
            active1_q <= active1_d;
            rr_last_q <= rr_last_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            src_q     <= src_d;
        end
    end

    assign m_valid = (state_q == ST_ISSUE);
    assign m_addr  = addr_q;
    assign m_len   = len_q;
    assign m_src   = src_q;

    // A channel is idle only once it is stopped and its last request has left the output register
    assign idle0 = ~active0_q & ~((state_q == ST_ISSUE) & ~src_q);
    assign idle1 = ~active1_q & ~((state_q == ST_ISSUE) &  src_q);

`ifdef ABM_ARB_COUNTERS_EN
    logic [31:0] cnt0_q, cnt1_q;

    // Downstream handshake counters; a start write clears and beats a same-cycle increment
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= 32'd0;
            cnt1_q <= 32'd0;
        end else begin
            if (start_wstrobe & start0) begin
                cnt0_q <= 32'd0;
            end else if (m_hs & ~src_q) begin
                cnt0_q <= cnt0_q + 32'd1;
            end
            if (start_wstrobe & start1) begin
                cnt1_q <= 32'd0;
            end else if (m_hs & src_q) begin
                cnt1_q <= cnt1_q + 32'd1;
            end
        end
    end

    assign abm0_counter = cnt0_q;
    assign abm1_counter = cnt1_q;
`else
    assign abm0_counter = 32'd0;
    assign abm1_counter = 32'd0;
`endif

endmodule
